// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: fetches 64-bit memory words, splits them into 32-bit instructions and
// presents them through a show-ahead FIFO with flush/redirect support.  Rev 1.0
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_pc,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [63:0]            mem_data,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [31:0]            ir,
  output logic [ADDR_W-1:0]      ir_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_run;

  logic [31:0]       r_ir_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_push_n;
  logic [PTR_W-1:0]  w_wptr1;
  logic [ADDR_W-1:0] w_flush_pc;
  logic [ADDR_W-1:0] w_line_addr;
  logic [ADDR_W-1:0] w_next_line;
  logic [ADDR_W-1:0] w_hi_pc;
  logic              w_issue;
  logic              w_push;
  logic              w_push2;
  logic              w_pop;

  assign w_flush_pc  = flush_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign w_line_addr = {3'b000, r_fetch_pc[ADDR_W-1:3]};
  assign w_next_line = {r_fetch_pc[ADDR_W-1:3] + (ADDR_W-3)'(1), 3'b000};
  assign w_hi_pc     = {r_fetch_pc[ADDR_W-1:3], 3'b100};
  assign w_free      = CNT_W'(DEPTH) - r_count;

  // r_run keeps the request line low while reset is held and for the release cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_issue        = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_fetch_pc_nxt = w_flush_pc;
        end else if (r_run && (w_free >= CNT_W'(2))) begin
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          w_fetch_pc_nxt = w_flush_pc;
          w_state_nxt    = mem_ack ? S_IDLE : S_DRAIN;
        end else if (mem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_next_line;
          w_state_nxt    = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (flush) begin
          w_fetch_pc_nxt = w_flush_pc;
        end
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_addr     <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_run      <= 1'b1;
      if (w_issue) begin
        r_addr <= w_line_addr;
      end
    end
  end

  // The issued address is latched so a drain keeps presenting it while fetch_pc moves on.
  assign mem_req  = w_issue | (r_state != S_IDLE);
  assign mem_addr = (r_state == S_IDLE) ? w_line_addr : r_addr;

  assign w_push2  = w_push & ~r_fetch_pc[2];
  assign w_pop    = ir_valid & ir_ready & ~flush;
  assign w_wptr1  = r_wptr + PTR_W'(1);
  assign w_push_n = w_push ? (w_push2 ? CNT_W'(2) : CNT_W'(1)) : '0;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ir_mem[r_wptr] <= r_fetch_pc[2] ? mem_data[63:32] : mem_data[31:0];
      r_pc_mem[r_wptr] <= r_fetch_pc;
      if (w_push2) begin
        r_ir_mem[w_wptr1] <= mem_data[63:32];
        r_pc_mem[w_wptr1] <= w_hi_pc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + w_push_n[PTR_W-1:0];
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + w_push_n - CNT_W'(w_pop);
    end
  end

  assign count    = r_count;
  assign ir_valid = (r_count != '0);
  assign ir       = ir_valid ? r_ir_mem[r_rptr] : '0;
  assign ir_pc    = ir_valid ? r_pc_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed checks of the prefetch queue against a variable-latency memory
// whose word k holds {2k+1, 2k}, so every instruction equals its byte PC divided by 4.
module tb_fetch_queue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [2:0]  count;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          acks;
  int          found;
  logic        busy;
  int          cnt;
  logic [28:0] raddr;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .flush_pc(flush_pc),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .ir      (ir),
    .ir_pc   (ir_pc),
    .count   (count)
  );

  function automatic logic [63:0] mword(input logic [28:0] k);
    logic [31:0] lo;
    lo = {2'b00, k, 1'b0};
    return {lo | 32'd1, lo};
  endfunction

  // Memory responder: acks `lat` cycles after the cycle the request is first seen.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack  <= 1'b0;
      mem_data <= '0;
      busy     <= 1'b0;
      cnt      <= 0;
      raddr    <= '0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      busy    <= 1'b0;
    end else if (busy) begin
      if (cnt <= 1) begin
        mem_ack  <= 1'b1;
        mem_data <= mword(raddr);
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mem_req) begin
      raddr <= mem_addr[28:0];
      if (lat <= 1) begin
        mem_ack  <= 1'b1;
        mem_data <= mword(mem_addr[28:0]);
      end else begin
        busy <= 1'b1;
        cnt  <= lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  // Pops n instructions (ir_ready must be 1) and checks PC/data order and line addresses.
  task automatic collect(input int n, input logic [31:0] pc0);
    logic [31:0] epc;
    logic [28:0] eline;
    int          got;
    epc   = pc0;
    eline = pc0[31:3];
    got   = 0;
    for (int i = 0; i < 80 && got < n; i++) begin
      if (mem_ack) begin
        chk("line_addr", {32'd0, mem_addr}, {35'd0, eline});
        eline = eline + 29'd1;
      end
      if (ir_valid) begin
        chk("ir_pc", {32'd0, ir_pc}, {32'd0, epc});
        chk("ir", {32'd0, ir}, {34'd0, epc[31:2]});
        epc = epc + 32'd4;
        got++;
      end
      step();
    end
    chk("collect_done", got, n);
  endtask

  initial begin
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_count", count, 0);

    // Streaming from PC 0 with an always-ready consumer.
    ir_ready = 1'b1;
    lat = 1;
    do_reset();
    collect(6, 32'h0);

    // Back-pressure: two fetches fill the queue, then pops release slots.
    ir_ready = 1'b0;
    do_reset();
    acks = 0;
    repeat (12) begin
      if (mem_ack) acks++;
      step();
    end
    chk("full_acks", acks, 2);
    chk("full_count", count, 4);
    chk("full_req", mem_req, 0);
    chk("full_head_ir", ir, 0);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    #1;
    chk("pop1_count", count, 3);
    chk("pop1_req", mem_req, 0);
    chk("pop1_ir", ir, 1);
    chk("pop1_ir_pc", ir_pc, 4);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    #1;
    chk("pop2_count", count, 2);
    chk("pop2_req", mem_req, 1);
    chk("pop2_addr", mem_addr, 2);

    // Flush from IDLE to an odd-word PC (low bits ignored).
    flush_pc = 32'h107;
    flush = 1'b1;
    #1;
    chk("flush_idle_req", mem_req, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_idle_count", count, 0);
    chk("flush_idle_valid", ir_valid, 0);
    chk("flush_idle_newreq", mem_req, 1);
    chk("flush_idle_addr", mem_addr, 32'h20);
    ir_ready = 1'b1;
    collect(3, 32'h104);

    // Flush during a slow request: old request drains, its data is dropped.
    lat = 5;
    do_reset();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        found = 1;
        break;
      end
      step();
    end
    chk("drain_wait_req", found, 1);
    step();
    flush_pc = 32'h300;
    flush = 1'b1;
    #1;
    chk("drain_hold_req", mem_req, 1);
    chk("drain_hold_addr", mem_addr, 0);
    step();
    flush = 1'b0;
    #1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_ack) begin
        found = 1;
        break;
      end
      chk("drain_req", mem_req, 1);
      chk("drain_addr", mem_addr, 0);
      chk("drain_count", count, 0);
      step();
    end
    chk("drain_ack_seen", found, 1);
    chk("drain_ack_addr", mem_addr, 0);
    step();
    chk("drain_after_count", count, 0);
    chk("drain_after_valid", ir_valid, 0);
    chk("drain_after_req", mem_req, 1);
    chk("drain_after_addr", mem_addr, 32'h60);
    collect(2, 32'h300);

    // Flush coincident with ack and pop.
    lat = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_ack && ir_valid) begin
        found = 1;
        break;
      end
      step();
    end
    chk("coinc_wait", found, 1);
    flush_pc = 32'h40;
    flush = 1'b1;
    #1;
    step();
    flush = 1'b0;
    #1;
    chk("coinc_count", count, 0);
    chk("coinc_valid", ir_valid, 0);
    chk("coinc_req", mem_req, 1);
    chk("coinc_addr", mem_addr, 8);
    collect(2, 32'h40);

    // Asynchronous reset in the middle of a request.
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_ack) begin
        found = 1;
        break;
      end
      step();
    end
    chk("arst_wait", found, 1);
    chk("arst_pre_req", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_ir_valid", ir_valid, 0);
    chk("arst_ir", ir, 0);
    chk("arst_ir_pc", ir_pc, 0);
    chk("arst_count", count, 0);

    // Address wrap at the top of the PC space.
    do_reset();
    flush_pc = 32'hFFFF_FFF8;
    flush = 1'b1;
    #1;
    step();
    flush = 1'b0;
    #1;
    chk("wrap_req", mem_req, 1);
    chk("wrap_addr", mem_addr, 32'h1FFF_FFFF);
    collect(3, 32'hFFFF_FFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
